// File: rtl/operand_mem_pkg.sv
// Shared types and constants for the operand memory block.
// No logic. Holds the run-control state encoding and the host bank-select codes.
// Nothing here applies backpressure.
package operand_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Values for wr_bank_i
    localparam logic BANK_OP1 = 1'b0;
    localparam logic BANK_OP2 = 1'b1;

endpackage

// File: rtl/operand_mem_if.sv
// Bundles the operand memory ports: compute side, host load, run control and readback.
// No logic and no latency of its own.
// Backpressure is carried only by wr_ready_o, which refuses host loads during a run.
//
// master: the host/compute side that drives requests.
// slave : operand_mem.
interface operand_mem_if #(
    parameter int MEM_WIDTH = 32,
    parameter int MEM_DEPTH = 8
);
    localparam int AW = $clog2(MEM_DEPTH);

    // compute block
    logic [AW-1:0]        op1_addr_i;
    logic [AW-1:0]        op2_addr_i;
    logic [AW-1:0]        res_addr_i;
    logic [MEM_WIDTH-1:0] res_data_i;
    logic [MEM_WIDTH-1:0] operand1_o;
    logic [MEM_WIDTH-1:0] operand2_o;
    // host operand load
    logic                 wr_valid_i;
    logic                 wr_ready_o;
    logic                 wr_bank_i;
    logic [AW-1:0]        wr_addr_i;
    logic [MEM_WIDTH-1:0] wr_data_i;
    // run control
    logic                 start_i;
    logic                 busy_o;
    logic                 done_o;
    // host result readback
    logic                 rd_valid_i;
    logic [AW-1:0]        rd_addr_i;
    logic                 rd_valid_o;
    logic [MEM_WIDTH-1:0] rd_data_o;

    modport master (
        output op1_addr_i, op2_addr_i, res_addr_i, res_data_i,
        output wr_valid_i, wr_bank_i, wr_addr_i, wr_data_i,
        output start_i, rd_valid_i, rd_addr_i,
        input  operand1_o, operand2_o, wr_ready_o, busy_o, done_o,
        input  rd_valid_o, rd_data_o
    );

    modport slave (
        input  op1_addr_i, op2_addr_i, res_addr_i, res_data_i,
        input  wr_valid_i, wr_bank_i, wr_addr_i, wr_data_i,
        input  start_i, rd_valid_i, rd_addr_i,
        output operand1_o, operand2_o, wr_ready_o, busy_o, done_o,
        output rd_valid_o, rd_data_o
    );

endinterface

// File: rtl/mem_bank.sv
// One storage bank: single combinational read port, single synchronous write port.
// Read latency 0 cycles; a write is visible on the read port from the next cycle.
// No backpressure; the write enable is qualified by the caller.
//
// Ports: clk_i/rst_i (sync active-high clear of every word), we_i/waddr_i/wdata_i
// write port, raddr_i/rdata_o read port.
module mem_bank #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Clear wins over write so a reset edge never stores data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/operand_mem.sv
// Operand store for a compute block: two host-loaded operand banks plus a result bank
// captured over one MEM_DEPTH-cycle run. Operand reads 0 cycles, readback 1 cycle.
// Host loads are refused (wr_ready_o low) while a run is in progress; readback never stalls.
//
// Ports: clk_i, rst_i (sync active-high), bus (operand_mem_if.slave) carrying
// compute addresses/data, host load handshake, start/busy/done and readback.
module operand_mem
    import operand_mem_pkg::*;
#(
    parameter int MEM_WIDTH = 32,
    parameter int MEM_DEPTH = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    operand_mem_if.slave bus
);

    localparam int           AW       = $clog2(MEM_DEPTH);
    localparam logic [AW:0]  CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]  CNT_LAST = (AW+1)'(MEM_DEPTH - 1);

    state_e               state_q;
    logic [AW:0]          cnt_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 wr_rdy_q;
    logic                 rd_vld_q;
    logic [MEM_WIDTH-1:0] rd_dat_q;
    logic [MEM_WIDTH-1:0] res_rdata;

    logic wr_fire;
    logic op1_we;
    logic op2_we;
    logic res_we;

    assign wr_fire = bus.wr_valid_i && wr_rdy_q;
    assign op1_we  = wr_fire && (bus.wr_bank_i == BANK_OP1);
    assign op2_we  = wr_fire && (bus.wr_bank_i == BANK_OP2);
    // The result bank is written every RUN cycle, whatever the compute side presents.
    assign res_we  = (state_q == RUN);

    mem_bank #(.WIDTH(MEM_WIDTH), .DEPTH(MEM_DEPTH)) u_op1_bank (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (op1_we),
        .waddr_i (bus.wr_addr_i),
        .wdata_i (bus.wr_data_i),
        .raddr_i (bus.op1_addr_i),
        .rdata_o (bus.operand1_o)
    );

    mem_bank #(.WIDTH(MEM_WIDTH), .DEPTH(MEM_DEPTH)) u_op2_bank (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (op2_we),
        .waddr_i (bus.wr_addr_i),
        .wdata_i (bus.wr_data_i),
        .raddr_i (bus.op2_addr_i),
        .rdata_o (bus.operand2_o)
    );

    mem_bank #(.WIDTH(MEM_WIDTH), .DEPTH(MEM_DEPTH)) u_res_bank (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (res_we),
        .waddr_i (bus.res_addr_i),
        .wdata_i (bus.res_data_i),
        .raddr_i (bus.rd_addr_i),
        .rdata_o (res_rdata)
    );

    // Run control. Flags are registered alongside the state so they change on the
    // same edge as the state they describe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_rdy_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start_i) begin
                        state_q  <= RUN;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        wr_rdy_q <= 1'b0;
                    end
                end
                RUN: begin
                    // start_i is deliberately ignored here.
                    cnt_q <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_q  <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        wr_rdy_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                    wr_rdy_q <= 1'b1;
                end
            endcase
        end
    end

    // Readback samples the bank before this edge's result write lands, so a read of
    // the address being captured returns the previous contents.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_vld_q <= 1'b0;
            rd_dat_q <= '0;
        end else begin
            rd_vld_q <= bus.rd_valid_i;
            if (bus.rd_valid_i) begin
                rd_dat_q <= res_rdata;
            end
        end
    end

    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.wr_ready_o = wr_rdy_q;
    assign bus.rd_valid_o = rd_vld_q;
    assign bus.rd_data_o  = rd_dat_q;

endmodule

// File: tb/tb_operand_mem.sv
module tb_operand_mem;
    import operand_mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    operand_mem_if #(.MEM_WIDTH(32), .MEM_DEPTH(8)) bus ();

    operand_mem #(.MEM_WIDTH(32), .MEM_DEPTH(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Compute-side model: free-running incrementing address, result = op1 + op2 + bias,
    // optionally replaced by 0xDEADBEEF when the address is 5.
    logic [2:0]  free_addr = 3'd0;
    logic        auto_addr = 1'b0;
    logic [2:0]  man_op1_addr = 3'd0;
    logic [2:0]  man_op2_addr = 3'd0;
    logic [31:0] bias = 32'd0;
    logic        dead_en = 1'b0;

    always @(posedge clk) free_addr <= free_addr + 3'd1;

    assign bus.op1_addr_i = auto_addr ? free_addr : man_op1_addr;
    assign bus.op2_addr_i = auto_addr ? free_addr : man_op2_addr;
    assign bus.res_addr_i = free_addr;
    assign bus.res_data_i = (dead_en && free_addr == 3'd5) ? 32'hDEADBEEF
                          : bus.operand1_o + bus.operand2_o + bias;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_wr(input logic bank, input int addr, input logic [31:0] data);
        bus.wr_valid_i = 1'b1;
        bus.wr_bank_i  = bank;
        bus.wr_addr_i  = 3'(addr);
        bus.wr_data_i  = data;
        step();
        bus.wr_valid_i = 1'b0;
    endtask

    task automatic rb(input int addr, input logic [31:0] exp, input string tag);
        bus.rd_valid_i = 1'b1;
        bus.rd_addr_i  = 3'(addr);
        step();
        bus.rd_valid_i = 1'b0;
        check({tag, "_vld"}, 64'(bus.rd_valid_o), 64'd1);
        check(tag, 64'(bus.rd_data_o), 64'(exp));
    endtask

    // Pulse start, then count RUN cycles until done_o. Optional extras inside the run:
    // a second start at cycle start_at, a host write at cycle wr_at, and a readback of
    // address 5 in the cycle it is captured (expecting old_val).
    task automatic do_run(input int start_at, input int wr_at, input bit dead_rd,
                          input logic [31:0] old_val, input string tag);
        int  n;
        bit  rd_pend;
        bit  rd_done;
        n = 0; rd_pend = 0; rd_done = 0;
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        check({tag, "_busy"}, 64'(bus.busy_o), 64'd1);
        check({tag, "_wr_rdy_run"}, 64'(bus.wr_ready_o), 64'd0);
        while (!bus.done_o && n < 20) begin
            bus.start_i = (n + 1 == start_at);
            if (n + 1 == wr_at) begin
                bus.wr_valid_i = 1'b1;
                bus.wr_bank_i  = BANK_OP1;
                bus.wr_addr_i  = 3'd0;
                bus.wr_data_i  = 32'd99;
            end
            if (dead_rd && !rd_done && free_addr == 3'd5) begin
                bus.rd_valid_i = 1'b1;
                bus.rd_addr_i  = free_addr;
                rd_pend = 1;
            end
            step();
            n++;
            bus.start_i    = 1'b0;
            bus.wr_valid_i = 1'b0;
            bus.rd_valid_i = 1'b0;
            if (rd_pend) begin
                check({tag, "_rd_old_vld"}, 64'(bus.rd_valid_o), 64'd1);
                check({tag, "_rd_old"}, 64'(bus.rd_data_o), 64'(old_val));
                rd_pend = 0;
                rd_done = 1;
            end
        end
        check({tag, "_cycles"}, 64'(n), 64'd8);
        check({tag, "_busy_end"}, 64'(bus.busy_o), 64'd0);
        if (dead_rd) check({tag, "_rd_seen"}, 64'(rd_done), 64'd1);
    endtask

    initial begin
        bus.wr_valid_i = 1'b0;
        bus.wr_bank_i  = 1'b0;
        bus.wr_addr_i  = 3'd0;
        bus.wr_data_i  = 32'd0;
        bus.start_i    = 1'b0;
        bus.rd_valid_i = 1'b0;
        bus.rd_addr_i  = 3'd0;

        // Reset state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        man_op1_addr = 3'd3;
        #1;
        check("rst_op1_3", 64'(bus.operand1_o), 64'd0);
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_done", 64'(bus.done_o), 64'd0);
        check("rst_wr_rdy", 64'(bus.wr_ready_o), 64'd1);
        check("rst_rd_vld", 64'(bus.rd_valid_o), 64'd0);
        check("rst_rd_dat", 64'(bus.rd_data_o), 64'd0);

        // Operand load: op1[k] = k, op2[k] = 10k
        for (int k = 0; k < 8; k++) begin
            host_wr(BANK_OP1, k, 32'(k));
            host_wr(BANK_OP2, k, 32'(10 * k));
        end
        man_op1_addr = 3'd5;
        man_op2_addr = 3'd5;
        #1;
        check("ld_op1_5", 64'(bus.operand1_o), 64'd5);
        check("ld_op2_5", 64'(bus.operand2_o), 64'd50);
        man_op2_addr = 3'd7;
        #1;
        check("ld_op2_7", 64'(bus.operand2_o), 64'd70);

        // Run 1 with a host write attempted in RUN cycle 2
        auto_addr = 1'b1;
        bias = 32'd0;
        do_run(0, 2, 1'b0, 32'd0, "run1");
        check("run1_done", 64'(bus.done_o), 64'd1);
        check("run1_wr_rdy_done", 64'(bus.wr_ready_o), 64'd1);
        auto_addr = 1'b0;
        man_op1_addr = 3'd0;
        #1;
        check("wr_blocked_in_run", 64'(bus.operand1_o), 64'd0);
        host_wr(BANK_OP1, 0, 32'd99);
        check("wr_accept_in_done", 64'(bus.operand1_o), 64'd99);
        host_wr(BANK_OP1, 0, 32'd0);
        check("wr_restore", 64'(bus.operand1_o), 64'd0);
        for (int k = 0; k < 8; k++) rb(k, 32'(11 * k), $sformatf("rb1_%0d", k));
        step();
        check("rb_idle_vld", 64'(bus.rd_valid_o), 64'd0);
        check("rb_idle_hold", 64'(bus.rd_data_o), 64'd77);

        // Run 2: stray start in RUN cycle 3, results overwritten with +100
        auto_addr = 1'b1;
        bias = 32'd100;
        do_run(3, 0, 1'b0, 32'd0, "run2");
        check("run2_done", 64'(bus.done_o), 64'd1);
        rb(0, 32'd100, "rb2_0");
        rb(3, 32'd133, "rb2_3");
        rb(7, 32'd177, "rb2_7");

        // Run 3: address 5 written with DEADBEEF while being read back
        bias = 32'd0;
        dead_en = 1'b1;
        do_run(0, 0, 1'b1, 32'd155, "run3");
        dead_en = 1'b0;
        rb(5, 32'hDEADBEEF, "rb3_5");
        rb(4, 32'd44, "rb3_4");

        // Reset in RUN cycle 4, with a readback request on the same edge
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        step();
        step();
        step();
        check("rst4_busy_before", 64'(bus.busy_o), 64'd1);
        rst = 1'b1;
        bus.rd_valid_i = 1'b1;
        bus.rd_addr_i  = 3'd1;
        step();
        rst = 1'b0;
        bus.rd_valid_i = 1'b0;
        auto_addr = 1'b0;
        man_op1_addr = 3'd2;
        man_op2_addr = 3'd2;
        #1;
        check("rst4_busy", 64'(bus.busy_o), 64'd0);
        check("rst4_done", 64'(bus.done_o), 64'd0);
        check("rst4_wr_rdy", 64'(bus.wr_ready_o), 64'd1);
        check("rst4_rd_vld", 64'(bus.rd_valid_o), 64'd0);
        check("rst4_op1", 64'(bus.operand1_o), 64'd0);
        check("rst4_op2", 64'(bus.operand2_o), 64'd0);
        rb(2, 32'd0, "rst4_res_2");
        rb(6, 32'd0, "rst4_res_6");
        step();
        check("rst4_stays_idle", 64'(bus.busy_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
